// File: rtl/mem_wb_elastic.sv
// MEM/WB pipeline register with a one-entry skid buffer.
// in_ready is registered so it never depends combinationally on out_ready.
module mem_wb_elastic #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              write_back_in,
    input  logic              mem_read_in,
    input  logic [REG_W-1:0]  dest_reg_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              write_back_out,
    output logic              mem_read_out,
    output logic [REG_W-1:0]  dest_reg_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  retired
);

    typedef struct packed {
        logic              wb;
        logic              mr;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
    } ent_t;

    ent_t             main_q, main_d;
    ent_t             skid_q, skid_d;
    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    ent_t in_ent;
    logic accept;
    logic consume;

    assign in_ent = '{wb: write_back_in, mr: mem_read_in, dest: dest_reg_in,
                      alu: alu_res_in, mem: mem_data_in};

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        accept   = in_valid & in_ready_q;
        consume  = main_v_q & out_ready;

        // skid is only ever full while main is full, so an accept cannot
        // coincide with a skid-to-main promotion
        if (consume) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (accept) begin
                main_d   = in_ent;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (accept) begin
            if (main_v_q) begin
                skid_d   = in_ent;
                skid_v_d = 1'b1;
            end else begin
                main_d   = in_ent;
                main_v_d = 1'b1;
            end
        end

        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end

        // a consume on the flush edge still counts as retired
        retired_d  = retired_q + CNT_W'(consume);
        in_ready_d = ~skid_v_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
            retired_q  <= '0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
            retired_q  <= retired_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = main_v_q;
    assign write_back_out = main_q.wb;
    assign mem_read_out   = main_q.mr;
    assign dest_reg_out   = main_q.dest;
    assign alu_res_out    = main_q.alu;
    assign mem_data_out   = main_q.mem;
    assign wb_data        = main_q.mr ? main_q.mem : main_q.alu;
    assign wb_we          = main_v_q & main_q.wb & (main_q.dest != '0);
    assign occupancy      = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign retired        = retired_q;

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Self-checking bench for mem_wb_elastic: directed vector table, random
// traffic against a FIFO reference model, wrap and async-reset sequences.
module tb_mem_wb_elastic;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        write_back_in = 1'b0;
    logic        mem_read_in = 1'b0;
    logic [4:0]  dest_reg_in = '0;
    logic [31:0] alu_res_in = '0;
    logic [31:0] mem_data_in = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, write_back_out, mem_read_out, wb_we;
    logic [4:0]  dest_reg_out;
    logic [31:0] alu_res_out, mem_data_out, wb_data;
    logic [1:0]  occupancy;
    logic [15:0] retired;

    logic        w_in_ready, w_out_valid, w_write_back_out, w_mem_read_out, w_wb_we;
    logic [4:0]  w_dest_reg_out;
    logic [31:0] w_alu_res_out, w_mem_data_out, w_wb_data;
    logic [1:0]  w_occupancy;
    logic [1:0]  w_retired;

    mem_wb_elastic dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .write_back_in(write_back_in), .mem_read_in(mem_read_in), .dest_reg_in(dest_reg_in),
        .alu_res_in(alu_res_in), .mem_data_in(mem_data_in), .out_valid(out_valid),
        .out_ready(out_ready), .write_back_out(write_back_out), .mem_read_out(mem_read_out),
        .dest_reg_out(dest_reg_out), .alu_res_out(alu_res_out), .mem_data_out(mem_data_out),
        .wb_data(wb_data), .wb_we(wb_we), .occupancy(occupancy), .retired(retired)
    );

    // Narrow-counter copy sharing the same stimulus, used for the wrap check.
    mem_wb_elastic #(.CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
        .write_back_in(write_back_in), .mem_read_in(mem_read_in), .dest_reg_in(dest_reg_in),
        .alu_res_in(alu_res_in), .mem_data_in(mem_data_in), .out_valid(w_out_valid),
        .out_ready(out_ready), .write_back_out(w_write_back_out), .mem_read_out(w_mem_read_out),
        .dest_reg_out(w_dest_reg_out), .alu_res_out(w_alu_res_out), .mem_data_out(w_mem_data_out),
        .wb_data(w_wb_data), .wb_we(w_wb_we), .occupancy(w_occupancy), .retired(w_retired)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wb;
        logic        mr;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] mem;
    } ent_t;

    ent_t m_q[$];
    int   m_ret = 0;

    typedef struct {
        logic        fl, iv, wb, mr;
        logic [4:0]  dest;
        logic [31:0] alu, mem;
        logic        ordy;
        int          occ;
        logic        ov, ir, we;
        logic [31:0] wbd, alu_o;
        int          ret;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ret = 0;
    endtask

    // FIFO of at most two entries; inputs are sampled before the edge.
    task automatic model_step();
        bit acc, con;
        ent_t e;
        acc = in_valid && (m_q.size() < 2);
        con = out_ready && (m_q.size() > 0);
        e = '{write_back_in, mem_read_in, dest_reg_in, alu_res_in, mem_data_in};
        if (con) m_ret = (m_ret + 1) % 65536;
        if (flush) begin
            m_q.delete();
        end else begin
            if (con) void'(m_q.pop_front());
            if (acc) m_q.push_back(e);
        end
    endtask

    task automatic check_model();
        ent_t h;
        chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
        chk("occupancy", 64'(occupancy), 64'(m_q.size()));
        chk("in_ready", 64'(in_ready), 64'(m_q.size() < 2));
        chk("retired", 64'(retired), 64'(m_ret));
        chk("retired_w", 64'(w_retired), 64'(m_ret % 4));
        if (m_q.size() > 0) begin
            h = m_q[0];
            chk("wb_out", 64'(write_back_out), 64'(h.wb));
            chk("mr_out", 64'(mem_read_out), 64'(h.mr));
            chk("dest_out", 64'(dest_reg_out), 64'(h.dest));
            chk("alu_out", 64'(alu_res_out), 64'(h.alu));
            chk("mem_out", 64'(mem_data_out), 64'(h.mem));
            chk("wb_data", 64'(wb_data), 64'(h.mr ? h.mem : h.alu));
            chk("wb_we", 64'(wb_we), 64'(h.wb && h.dest != 0));
        end else begin
            chk("wb_we_empty", 64'(wb_we), 64'd0);
        end
    endtask

    task automatic do_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input logic fl, input logic iv, input logic wb, input logic mr,
                         input logic [4:0] dest, input logic [31:0] alu,
                         input logic [31:0] mem, input logic ordy);
        flush = fl; in_valid = iv; write_back_in = wb; mem_read_in = mr;
        dest_reg_in = dest; alu_res_in = alu; mem_data_in = mem; out_ready = ordy;
    endtask

    task automatic reset_dut();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic vec_t mk(input logic fl, iv, wb, mr, input logic [4:0] dest,
                                input logic [31:0] alu, mem, input logic ordy,
                                input int occ, input logic ov, ir, we,
                                input logic [31:0] wbd, alu_o, input int ret);
        vec_t v;
        v.fl = fl; v.iv = iv; v.wb = wb; v.mr = mr; v.dest = dest; v.alu = alu;
        v.mem = mem; v.ordy = ordy; v.occ = occ; v.ov = ov; v.ir = ir; v.we = we;
        v.wbd = wbd; v.alu_o = alu_o; v.ret = ret;
        return v;
    endfunction

    initial begin
        int wrap_seq[4];
        wrap_seq = '{1, 2, 3, 0};

        // streaming
        tbl[0]  = mk(0,1,1,0,3,32'h10,0,1,            1,1,1,1,32'h10,32'h10,0);
        tbl[1]  = mk(0,1,1,0,3,32'h11,0,1,            1,1,1,1,32'h11,32'h11,1);
        tbl[2]  = mk(0,1,1,0,3,32'h12,0,1,            1,1,1,1,32'h12,32'h12,2);
        tbl[3]  = mk(0,1,1,0,3,32'h13,0,1,            1,1,1,1,32'h13,32'h13,3);
        tbl[4]  = mk(0,1,1,0,3,32'h14,0,1,            1,1,1,1,32'h14,32'h14,4);
        tbl[5]  = mk(0,0,0,0,0,0,0,1,                 0,0,1,0,0,0,5);
        // backpressure
        tbl[6]  = mk(0,1,0,0,2,32'hA0,0,0,            1,1,1,0,32'hA0,32'hA0,5);
        tbl[7]  = mk(0,1,0,0,2,32'hB0,0,0,            2,1,0,0,32'hA0,32'hA0,5);
        tbl[8]  = mk(0,1,0,0,2,32'hC0,0,0,            2,1,0,0,32'hA0,32'hA0,5);
        tbl[9]  = mk(0,0,0,0,0,0,0,1,                 1,1,1,0,32'hB0,32'hB0,6);
        tbl[10] = mk(0,0,0,0,0,0,0,1,                 0,0,1,0,0,0,7);
        // write-back select
        tbl[11] = mk(0,1,1,1,5,32'h4,32'hDEADBEEF,0,  1,1,1,1,32'hDEADBEEF,32'h4,7);
        tbl[12] = mk(0,0,0,0,0,0,0,1,                 0,0,1,0,0,0,8);
        tbl[13] = mk(0,1,1,1,0,32'h4,32'hDEADBEEF,0,  1,1,1,0,32'hDEADBEEF,32'h4,8);
        // flush with two held and a same-cycle input
        tbl[14] = mk(0,1,1,0,7,32'h55,0,0,            2,1,0,0,32'hDEADBEEF,32'h4,8);
        tbl[15] = mk(1,1,1,0,7,32'h66,0,1,            0,0,1,0,0,0,9);
        tbl[16] = mk(0,0,0,0,0,0,0,1,                 0,0,1,0,0,0,9);

        #2 rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].wb, tbl[i].mr, tbl[i].dest,
                  tbl[i].alu, tbl[i].mem, tbl[i].ordy);
            do_cycle();
            chk($sformatf("v%0d_occ", i), 64'(occupancy), 64'(tbl[i].occ));
            chk($sformatf("v%0d_ov", i), 64'(out_valid), 64'(tbl[i].ov));
            chk($sformatf("v%0d_ir", i), 64'(in_ready), 64'(tbl[i].ir));
            chk($sformatf("v%0d_we", i), 64'(wb_we), 64'(tbl[i].we));
            chk($sformatf("v%0d_ret", i), 64'(retired), 64'(tbl[i].ret));
            if (tbl[i].ov) begin
                chk($sformatf("v%0d_alu", i), 64'(alu_res_out), 64'(tbl[i].alu_o));
                chk($sformatf("v%0d_wbd", i), 64'(wb_data), 64'(tbl[i].wbd));
            end
        end

        // random traffic with occasional flush
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom % 20) == 0, ($urandom % 4) != 0, 1'($urandom), 1'($urandom),
                  5'($urandom % 4), $urandom, $urandom, ($urandom % 3) != 0);
            do_cycle();
        end

        // sustained full throughput
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 1, 0, 5'd9, 32'h100 + 32'(i), 0, 1);
            do_cycle();
        end

        // counter wrap on the narrow instance, then async reset mid-transfer
        @(negedge clk);
        reset_dut();
        for (int k = 1; k <= 8; k++) begin
            drive(0, 1, 1, 0, 5'd3, 32'h200 + 32'(k), 0, 1);
            do_cycle();
            if (k >= 2 && k <= 5)
                chk($sformatf("wrap_%0d", k), 64'(w_retired), 64'(wrap_seq[k-2]));
        end
        drive(0, 1, 1, 0, 5'd3, 32'h2FF, 0, 0);
        do_cycle();
        chk("pre_rst_occ", 64'(occupancy), 64'd2);
        chk("pre_rst_ret", 64'(retired), 64'd7);
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_occupancy", 64'(occupancy), 64'd0);
        chk("arst_retired", 64'(retired), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_wb_we", 64'(wb_we), 64'd0);
        chk("arst_wb_data", 64'(wb_data), 64'd0);
        chk("arst_alu_out", 64'(alu_res_out), 64'd0);
        chk("arst_mem_out", 64'(mem_data_out), 64'd0);
        chk("arst_dest_out", 64'(dest_reg_out), 64'd0);
        chk("arst_wb_out", 64'(write_back_out), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1, 1, 0, 5'd4, 32'h77, 0, 0);
        do_cycle();
        chk("post_rst_alu", 64'(alu_res_out), 64'h77);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        do_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_elastic.md
MEM_WB_ELASTIC -- requirements
Module: mem_wb_elastic

Interface
REQ-001 Parameter DATA_W, default 32, width of ALU result, memory data and write-back data.
REQ-002 Parameter REG_W, default 5, width of destination register index.
REQ-003 Parameter CNT_W, default 16, width of retired-entry counter.
REQ-004 Ports:
- clk  in  1  sole clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry this cycle.
- write_back_in  in  1  entry writes the register file.
- mem_read_in  in  1  entry result comes from memory data.
- dest_reg_in  in  REG_W  destination register index.
- alu_res_in  in  DATA_W  ALU result.
- mem_data_in  in  DATA_W  memory read data.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream consumes head this cycle.
- write_back_out, mem_read_out, dest_reg_out, alu_res_out, mem_data_out  out  1/1/REG_W/DATA_W/DATA_W  head entry fields.
- wb_data  out  DATA_W  selected write-back value.
- wb_we  out  1  register-file write enable.
- occupancy  out  2  entries held (0..2).
- retired  out  CNT_W  count of consumed entries.

Function
REQ-005 Storage SHALL be two entries: main (drives all *_out fields) and skid.
REQ-006 in_ready SHALL be registered and equal to NOT(skid full); never depends combinationally on out_ready.
REQ-007 Accept occurs when in_valid and in_ready are high at a rising edge; consume occurs when out_valid and out_ready are high.
REQ-008 Accept with main empty or main consumed the same cycle (skid empty): entry loads main; latency 1 cycle input to out_valid.
REQ-009 Accept with main full and not consumed: entry loads skid; in_ready drops the next cycle.
REQ-010 Consume with skid full: skid moves to main the same edge; skid becomes empty and in_ready rises the next cycle.
REQ-011 Simultaneous accept and consume with skid full is impossible (in_ready low); with skid empty, main is replaced by the new entry, occupancy unchanged.
REQ-012 Entry order SHALL be preserved; no entry dropped or duplicated without flush.
REQ-013 wb_data SHALL be mem_data_out when mem_read_out is 1, else alu_res_out (combinational from main).
REQ-014 wb_we SHALL be out_valid AND write_back_out AND (dest_reg_out != 0).
REQ-015 occupancy SHALL equal number of valid entries after each edge.
REQ-016 retired SHALL increment by 1 on each consume, wrapping from 2^CNT_W-1 to 0; not affected by flush.
REQ-017 flush SHALL clear both valid bits at the edge, override any same-cycle accept (input dropped) and consume (consume still counted in retired); payload fields need not clear; in_ready is 1 the cycle after flush.
REQ-018 With out_ready held high and in_valid held high, throughput SHALL be one entry per cycle indefinitely.

Reset
REQ-019 rst low SHALL immediately, without clk, force: both valid bits 0, all payload fields 0, wb_data 0, wb_we 0, occupancy 0, retired 0, in_ready 1.
REQ-020 Reset asserted mid-transfer SHALL discard all entries; first accept after rst deasserts behaves as from empty.

Verification
REQ-021 Streaming: out_ready=1, entries alu_res 0x10..0x14, write_back=1, dest=3 -> each appears one cycle later in order, wb_we=1, retired=5.
REQ-022 Backpressure: out_ready=0, send A,B -> occupancy 2, in_ready 0, out shows A; raise out_ready -> A then B consumed in order, in_ready returns 1.
REQ-023 Write-back select: mem_read=1, mem_data 0xDEADBEEF, alu 0x4 -> wb_data 0xDEADBEEF; dest=0 -> wb_we 0.
REQ-024 Flush with occupancy 2 and in_valid=1 -> next cycle occupancy 0, out_valid 0, input entry absent at output.
REQ-025 Async reset: assert rst low between clock edges with occupancy 2 and retired 7 -> outputs zero, in_ready 1 before next edge.
REQ-026 Wrap: CNT_W=2, four consumes -> retired sequence 1,2,3,0.
